// File: rtl/diag_drain.sv
// Anti-diagonal drain for the NxN systolic result path: snapshots result/addend matrices on start
// and streams one anti-diagonal per beat, optionally FP32-summed with the addend.

module fpadd (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_sub, w_up;
    logic [31:0] w_l, w_s;
    logic [7:0]  w_el, w_es, w_d;
    logic [26:0] w_ml, w_ms, w_ms_al, w_m;
    logic [27:0] w_sum;
    logic [9:0]  w_e;
    logic [24:0] w_mr;

    always_comb begin
        w_a_nan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
        w_b_nan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
        w_a_inf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
        w_b_inf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);

        // l is the larger magnitude operand; its sign is the result sign
        w_swap = i_b[30:0] > i_a[30:0];
        w_l    = w_swap ? i_b : i_a;
        w_s    = w_swap ? i_a : i_b;
        w_el   = (w_l[30:23] == 8'd0) ? 8'd1 : w_l[30:23];
        w_es   = (w_s[30:23] == 8'd0) ? 8'd1 : w_s[30:23];
        w_ml   = {w_l[30:23] != 8'd0, w_l[22:0], 3'b000};
        w_ms   = {w_s[30:23] != 8'd0, w_s[22:0], 3'b000};
        w_d    = w_el - w_es;

        if (w_d >= 8'd27)
            w_ms_al = {26'd0, |w_ms};
        else
            w_ms_al = (w_ms >> w_d) | {26'd0, |(w_ms << (8'd27 - w_d))};

        w_sub = w_l[31] ^ w_s[31];
        w_sum = w_sub ? ({1'b0, w_ml} - {1'b0, w_ms_al}) : ({1'b0, w_ml} + {1'b0, w_ms_al});
        w_e   = {2'b00, w_el};

        if (w_sum[27]) begin
            w_m = {w_sum[27:2], |w_sum[1:0]};
            w_e = w_e + 10'd1;
        end else begin
            w_m = w_sum[26:0];
        end

        // normalise left, stopping at the denormal exponent floor
        for (int i = 0; i < 26; i++) begin
            if (!w_m[26] && (w_e > 10'd1)) begin
                w_m = w_m << 1;
                w_e = w_e - 10'd1;
            end
        end

        w_up = w_m[2] & (w_m[3] | w_m[1] | w_m[0]);
        w_mr = {1'b0, w_m[26:3]} + {24'd0, w_up};
        if (w_mr[24]) begin
            w_mr = w_mr >> 1;
            w_e  = w_e + 10'd1;
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[31] != i_b[31])))
            o_sum = 32'h7FC0_0000;
        else if (w_a_inf)
            o_sum = i_a;
        else if (w_b_inf)
            o_sum = i_b;
        else if (w_m == 27'd0)
            o_sum = {~w_sub & w_l[31], 31'd0};
        else if (w_e >= 10'd255)
            o_sum = {w_l[31], 8'hFF, 23'd0};
        else
            o_sum = {w_l[31], (w_mr[23] ? w_e[7:0] : 8'd0), w_mr[22:0]};
    end
endmodule

module diag_drain #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int KW = $clog2(2*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              acc,
    input  logic [N*N*W-1:0]  r_flat,
    input  logic [N*N*W-1:0]  a_flat,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [N*W-1:0]    d_flat,
    output logic [N-1:0]      d_mask,
    output logic [KW-1:0]     d_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam logic [KW-1:0] LAST_K = KW'(2*N-2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [KW-1:0]      r_next_k, w_next_k_nxt;
    logic               r_acc, w_acc_nxt;
    logic               r_out_valid, w_valid_nxt;
    logic               r_out_last, w_last_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [N*W-1:0]     r_d_flat, w_flat_nxt;
    logic [N-1:0]       r_d_mask, w_mask_nxt;
    logic [KW-1:0]      r_d_idx, w_idx_nxt;
    logic               w_snap_en;

    logic [N*N*W-1:0]   r_snap_r, r_snap_a;

    logic [W-1:0]       w_lane_r   [N];
    logic [W-1:0]       w_lane_a   [N];
    logic [W-1:0]       w_lane_sum [N];
    logic [N-1:0]       w_lane_act;
    logic [N*W-1:0]     w_beat_flat;

    always_comb begin : lane_map
        int k_i, row_i, col_i;
        k_i        = int'(r_next_k);
        row_i      = 0;
        col_i      = 0;
        w_lane_act = '0;
        for (int j = 0; j < N; j++) begin
            w_lane_r[j] = '0;
            w_lane_a[j] = '0;
            if (k_i < N) begin
                w_lane_act[j] = (j <= k_i);
                row_i         = j;
                col_i         = k_i - j;
            end else begin
                w_lane_act[j] = (j < 2*N - 1 - k_i);
                row_i         = k_i - N + 1 + j;
                col_i         = N - 1 - j;
            end
            // inactive lanes keep zero on both adder inputs
            if (w_lane_act[j]) begin
                w_lane_r[j] = r_snap_r[(row_i*N + col_i)*W +: W];
                w_lane_a[j] = r_snap_a[(row_i*N + col_i)*W +: W];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        if (W == 32) begin : g_fp
            fpadd u_fpadd (
                .i_a   (w_lane_r[j]),
                .i_b   (w_lane_a[j]),
                .o_sum (w_lane_sum[j])
            );
        end else begin : g_nofp
            assign w_lane_sum[j] = w_lane_r[j];
        end
    end

    always_comb begin
        w_beat_flat = '0;
        for (int j = 0; j < N; j++) begin
            if (w_lane_act[j])
                w_beat_flat[j*W +: W] = r_acc ? w_lane_sum[j] : w_lane_r[j];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_next_k_nxt = r_next_k;
        w_acc_nxt    = r_acc;
        w_valid_nxt  = r_out_valid;
        w_last_nxt   = r_out_last;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_flat_nxt   = r_d_flat;
        w_mask_nxt   = r_d_mask;
        w_idx_nxt    = r_d_idx;
        w_snap_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_snap_en    = 1'b1;
                    w_acc_nxt    = acc;
                    w_next_k_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = RUN;
                end
            end
            RUN: begin
                if (!r_out_valid || out_ready) begin
                    if (r_next_k <= LAST_K) begin
                        w_flat_nxt   = w_beat_flat;
                        w_mask_nxt   = w_lane_act;
                        w_idx_nxt    = r_next_k;
                        w_valid_nxt  = 1'b1;
                        w_last_nxt   = (r_next_k == LAST_K);
                        w_next_k_nxt = r_next_k + KW'(1);
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_next_k    <= '0;
            r_acc       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_d_flat    <= '0;
            r_d_mask    <= '0;
            r_d_idx     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_next_k    <= w_next_k_nxt;
            r_acc       <= w_acc_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_d_flat    <= w_flat_nxt;
            r_d_mask    <= w_mask_nxt;
            r_d_idx     <= w_idx_nxt;
        end
    end

    // snapshot buffers carry data only, so they are left out of reset
    always_ff @(posedge clk) begin
        if (w_snap_en) begin
            r_snap_r <= r_flat;
            r_snap_a <= a_flat;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign d_flat    = r_d_flat;
    assign d_mask    = r_d_mask;
    assign d_idx     = r_d_idx;
endmodule

// File: tb/tb_diag_drain.sv
// Randomised bench for diag_drain: an N=4 instance checked against a diagonal-walk model,
// plus a short N=2 directed drain.

module tb_diag_drain;
    logic         clk, rst_n, start, acc, out_ready;
    logic [511:0] r_flat, a_flat;
    logic         out_valid, out_last, busy, done;
    logic [127:0] d_flat;
    logic [3:0]   d_mask;
    logic [2:0]   d_idx;

    logic         start2, acc2, ready2;
    logic [127:0] r_flat2, a_flat2;
    logic         valid2, last2, busy2, done2;
    logic [63:0]  d_flat2;
    logic [1:0]   mask2;
    logic [1:0]   idx2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_r  [16];
    int          m_ri [16];
    int          m_ai [16];
    bit          m_acc;

    diag_drain #(.N(4), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc),
        .r_flat(r_flat), .a_flat(a_flat), .out_ready(out_ready),
        .out_valid(out_valid), .d_flat(d_flat), .d_mask(d_mask), .d_idx(d_idx),
        .out_last(out_last), .busy(busy), .done(done)
    );

    diag_drain #(.N(2), .W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .acc(acc2),
        .r_flat(r_flat2), .a_flat(a_flat2), .out_ready(ready2),
        .out_valid(valid2), .d_flat(d_flat2), .d_mask(mask2), .d_idx(idx2),
        .out_last(last2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // exact FP32 encoding of a small integer
    function automatic logic [31:0] fp_enc(input int v);
        logic        s;
        int          a, p;
        logic [31:0] f, mant;
        if (v == 0) return 32'd0;
        s = (v < 0);
        a = s ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if ((a >> i) != 0) p = i;
        f    = a;
        mant = (f << (23 - p)) & 32'h007F_FFFF;
        return {s, 8'(127 + p), mant[22:0]};
    endfunction

    // anti-diagonal k holds every (i,c) with i+c==k, lanes filled in ascending row order
    function automatic void model_beat(input int k, output logic [127:0] d, output logic [3:0] m);
        int j;
        d = '0;
        m = '0;
        j = 0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++)
                if (i + c == k) begin
                    d[j*32 +: 32] = m_acc ? fp_enc(m_ri[i*4+c] + m_ai[i*4+c]) : m_r[i*4+c];
                    m[j] = 1'b1;
                    j++;
                end
    endfunction

    // kind 0: element = index, 1: random raw pass-through, 2: random integer sums, 3: 1.0 + 2.0
    task automatic load(input int kind);
        for (int e = 0; e < 16; e++) begin
            case (kind)
                0: begin m_r[e] = 32'(e); m_ri[e] = 0; m_ai[e] = 0; end
                1: begin m_r[e] = $urandom; m_ri[e] = 0; m_ai[e] = 0; end
                2: begin
                    m_ri[e] = $urandom_range(0, 2000) - 1000;
                    m_ai[e] = ($urandom_range(0, 4) == 0) ? -m_ri[e] : $urandom_range(0, 2000) - 1000;
                    m_r[e]  = fp_enc(m_ri[e]);
                end
                default: begin m_ri[e] = 1; m_ai[e] = 2; m_r[e] = 32'h3F80_0000; end
            endcase
            r_flat[e*32 +: 32] = m_r[e];
            a_flat[e*32 +: 32] = (kind >= 2) ? fp_enc(m_ai[e]) : $urandom;
        end
        m_acc = (kind >= 2);
    endtask

    // bp 0: always ready, 1: random ready, 2: stall 3 cycles on k=2
    task automatic drain(input int bp, input bit perturb);
        int           k_exp, cyc, hold, dones;
        bit           pulsed;
        logic [127:0] ed;
        logic [3:0]   em;
        start = 1'b1;
        acc   = m_acc;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
        chk("valid_pre", out_valid, 0);
        chk("done_pre", done, 0);
        k_exp = 0; cyc = 0; hold = 0; dones = 0; pulsed = 0;
        while (k_exp < 7 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) dones++;
            model_beat(k_exp, ed, em);
            chk("out_valid", out_valid, 1);
            chk("d_idx", d_idx, k_exp);
            chk("d_mask", d_mask, em);
            chk("d_flat", d_flat, ed);
            chk("out_last", out_last, k_exp == 6);
            chk("busy_run", busy, 1);
            case (bp)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (k_exp == 2 && hold < 3) begin out_ready = 1'b0; hold++; end
                    else out_ready = 1'b1;
                end
            endcase
            if (perturb) begin
                for (int e = 0; e < 16; e++) r_flat[e*32 +: 32] = $urandom;
                acc = ~acc;
                if (k_exp == 1 && !pulsed) begin start = 1'b1; pulsed = 1; end
            end
            if (out_ready) k_exp++;
        end
        chk("beats", k_exp, 7);
        if (bp == 0) chk("cycles", cyc, 7);
        @(negedge clk);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", out_valid, 0);
        chk("early_done", dones, 0);
    endtask

    initial begin
        logic [31:0] v2 [4];
        int          wait_cyc;
        rst_n = 1'b0; start = 1'b0; acc = 1'b0; out_ready = 1'b1;
        r_flat = '0; a_flat = '0;
        start2 = 1'b0; acc2 = 1'b0; ready2 = 1'b1; r_flat2 = '0; a_flat2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flat", d_flat, 0);
        chk("rst_mask", d_mask, 0);
        chk("rst_idx", d_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load(0); drain(0, 0);
        load(3); drain(0, 0);
        load(1); drain(2, 0);
        load(1); drain(0, 1);
        load(2); drain(0, 0);
        for (int t = 0; t < 8; t++) begin
            load(($urandom_range(0, 1) == 0) ? 1 : 2);
            drain(1, ($urandom_range(0, 2) == 0));
        end

        // asynchronous reset in the middle of a drain
        load(1);
        start = 1'b1; acc = m_acc; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!(out_valid && d_idx == 3'd4) && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("reach_k4", d_idx, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flat", d_flat, 0);
        chk("arst_mask", d_mask, 0);
        chk("arst_idx", d_idx, 0);
        @(negedge clk);
        chk("arst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", busy, 0);
        load(2); drain(0, 0);

        // N=2: beats r00 | r01,r10 | r11
        for (int e = 0; e < 4; e++) begin
            v2[e] = $urandom;
            r_flat2[e*32 +: 32] = v2[e];
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        chk("n2_v0", valid2, 1);
        chk("n2_m0", mask2, 2'b01);
        chk("n2_d0", d_flat2, {32'd0, v2[0]});
        chk("n2_l0", last2, 0);
        @(negedge clk);
        chk("n2_m1", mask2, 2'b11);
        chk("n2_d1", d_flat2, {v2[2], v2[1]});
        @(negedge clk);
        chk("n2_m2", mask2, 2'b01);
        chk("n2_d2", d_flat2, {32'd0, v2[3]});
        chk("n2_i2", idx2, 2);
        chk("n2_l2", last2, 1);
        @(negedge clk);
        chk("n2_done", done2, 1);
        chk("n2_busy", busy2, 0);
        @(negedge clk);
        chk("n2_done_off", done2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
